// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the MEM-stage data memory responder.
package data_mem_responder_pkg;

  localparam int          WORD_W        = 32;
  localparam logic [31:0] DEF_BASE_ADDR = 32'd1024;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/data_mem_responder_if.sv
// MEM-stage request/ready bus. err exists only when MEM_ERR_EN is defined.
// Handshake: the pipeline holds MEM_r_en/MEM_w_en/address/data_in stable while
// ready is low; an access completes in the one cycle where ready returns high.
interface data_mem_responder_if;
  import data_mem_responder_pkg::*;

  logic              MEM_r_en;
  logic              MEM_w_en;
  logic [WORD_W-1:0] address;
  logic [WORD_W-1:0] data_in;
  logic              ready;
  logic [WORD_W-1:0] data_out;
`ifdef MEM_ERR_EN
  logic              err;
`endif
  state_t            state;

  modport master (
    output MEM_r_en, MEM_w_en, address, data_in,
`ifdef MEM_ERR_EN
    input  err,
`endif
    input  ready, data_out, state
  );

  modport slave (
    input  MEM_r_en, MEM_w_en, address, data_in,
`ifdef MEM_ERR_EN
    output err,
`endif
    output ready, data_out, state
  );

endinterface

// File: rtl/data_mem_responder_mem_word_array.sv
// DEPTH x WIDTH word store: synchronous write, asynchronous read, async clear.
module mem_word_array #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    idx,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[idx] <= wdata;
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data memory responder for the MEM stage (IDLE/WAIT/DONE).
// Optional macro MEM_ERR_EN adds an err flag for out-of-range/misaligned accesses.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int          DEPTH     = 64,
  parameter int          LATENCY   = 4,
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR
) (
  input logic       clk,
  input logic       rst,
  data_mem_responder_if.slave bus
);

  localparam int          AW       = $clog2(DEPTH);
  localparam int          CW       = $clog2(LATENCY + 1);
  localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(4 * DEPTH);

  state_t            state, next_state;
  logic [CW-1:0]     cnt, cnt_next;
  logic              ready;
  logic [WORD_W-1:0] data_out;
  logic [WORD_W-1:0] rdata;
  logic [AW-1:0]     idx;
  logic              req, in_range, enter_done, we;

  assign req      = bus.MEM_r_en | bus.MEM_w_en;
  assign in_range = (bus.address >= BASE_ADDR) && ({1'b0, bus.address} < END_ADDR);
  assign idx      = AW'((bus.address - BASE_ADDR) >> 2);

  // DONE is only ever entered from IDLE/WAIT, so this marks the committing edge.
  assign enter_done = (next_state == DONE);
  assign we         = enter_done && bus.MEM_w_en && in_range;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    ready      = 1'b1;
    case (state)
      IDLE: begin
        if (req) begin
          ready = 1'b0;
          if (LATENCY == 1) begin
            next_state = DONE;
          end else begin
            next_state = WAIT;
            cnt_next   = CW'(1);
          end
        end
      end
      WAIT: begin
        ready = 1'b0;
        if (!req) begin
          next_state = IDLE;
          cnt_next   = '0;
        end else if (cnt == CW'(LATENCY - 1)) begin
          next_state = DONE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // A simultaneous read+write behaves as a write and returns zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out <= '0;
    end else if (enter_done && bus.MEM_r_en) begin
      data_out <= (bus.MEM_w_en || !in_range) ? '0 : rdata;
    end
  end

`ifdef MEM_ERR_EN
  logic err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else begin
      err <= enter_done && (!in_range || (bus.address[1:0] != 2'b00));
    end
  end

  assign bus.err = err;
`endif

  mem_word_array #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_W)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .idx   (idx),
    .wdata (bus.data_in),
    .rdata (rdata)
  );

  assign bus.ready    = ready;
  assign bus.data_out = data_out;
  assign bus.state    = state;

endmodule
